// File: rtl/cpu_bus_pkg.sv
//==============================================================================
// Module      : cpu_bus_pkg
// Description : Shared encodings for the cpu-to-memory bridge.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package cpu_bus_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_REQ  = 2'd1,
      RD_REQ  = 2'd2,
      RD_DONE = 2'd3
   } bridge_state_t;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

endpackage

`default_nettype wire

// File: rtl/wbuf_fifo.sv
//==============================================================================
// Module      : wbuf_fifo
// Description : Circular write-buffer FIFO holding address/data pairs; exposes
//               the head entry and, with CPU_MEM_BRIDGE_FWD_EN, every slot.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module wbuf_fifo #(
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int DEPTH = 4,
   localparam int c_IW = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  logic [AW-1:0] push_addr,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic [AW-1:0] head_addr,
   output logic [DW-1:0] head_data
`ifdef CPU_MEM_BRIDGE_FWD_EN
   ,
   output logic [c_IW-1:0] rd_idx,
   output logic [c_IW:0]   count,
   output logic [AW-1:0]   ent_addr [DEPTH],
   output logic [DW-1:0]   ent_data [DEPTH]
`endif
);

   localparam logic [c_IW:0] c_PTR_ONE = 1;

   logic [c_IW:0]   r_wr_ptr;
   logic [c_IW:0]   r_rd_ptr;
   logic [AW-1:0]   r_addr [DEPTH];
   logic [DW-1:0]   r_data [DEPTH];
   logic            w_do_push;
   logic            w_do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (r_wr_ptr[c_IW] != r_rd_ptr[c_IW]) &&
                  (r_wr_ptr[c_IW-1:0] == r_rd_ptr[c_IW-1:0]);

   assign w_do_push = push && (!full || pop);
   assign w_do_pop  = pop && !empty;

   assign head_addr = r_addr[r_rd_ptr[c_IW-1:0]];
   assign head_data = r_data[r_rd_ptr[c_IW-1:0]];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_addr[i] <= '0;
            r_data[i] <= '0;
         end
      end else begin
         if (w_do_push) begin
            r_addr[r_wr_ptr[c_IW-1:0]] <= push_addr;
            r_data[r_wr_ptr[c_IW-1:0]] <= push_data;
            r_wr_ptr                   <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
      end
   end

`ifdef CPU_MEM_BRIDGE_FWD_EN
   assign rd_idx = r_rd_ptr[c_IW-1:0];
   assign count  = r_wr_ptr - r_rd_ptr;

   for (genvar g = 0; g < DEPTH; g++) begin : g_ent
      assign ent_addr[g] = r_addr[g];
      assign ent_data[g] = r_data[g];
   end
`endif

endmodule

`default_nettype wire

// File: rtl/cpu_mem_bridge.sv
//==============================================================================
// Module      : cpu_mem_bridge
// Description : Converts the cpu bus into a req/ack memory handshake with a
//               posted write buffer. Define CPU_MEM_BRIDGE_FWD_EN to let reads
//               forward the youngest matching buffered write.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cpu_mem_bridge
   import cpu_bus_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int WBUF_DEPTH = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          cpu_valid,
   input  logic          cpu_rw,
   input  logic [AW-1:0] cpu_address,
   input  logic [DW-1:0] cpu_datao,
   output logic [DW-1:0] cpu_data,
   output logic          cpu_stall,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata
);

   localparam int c_IW = $clog2(WBUF_DEPTH);

   bridge_state_t r_state;
   bridge_state_t w_state_next;

   logic          r_mem_req;
   logic          r_mem_we;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_wdata;
   logic [DW-1:0] r_cpu_data;

   logic          w_full;
   logic          w_empty;
   logic [AW-1:0] w_head_addr;
   logic [DW-1:0] w_head_data;
   logic          w_push;
   logic          w_pop;
   logic          w_rd_pending;
   logic          w_wr_pending;
   logic          w_ack;
   logic          w_issue_wr;
   logic          w_issue_rd;
   logic          w_cap_rd;
   logic          w_cap_fwd;
   logic          w_drop_req;
   logic          w_fwd_hit;
   logic [DW-1:0] w_fwd_data;

   assign w_rd_pending = cpu_valid && (cpu_rw == RW_READ);
   assign w_wr_pending = cpu_valid && (cpu_rw == RW_WRITE);
   assign w_push       = w_wr_pending && !w_full;
   assign w_ack        = mem_ack && r_mem_req;

   // A read is held until its RD_DONE cycle; a write only while the buffer is full.
   assign cpu_stall = (w_rd_pending && (r_state != RD_DONE)) ||
                      (w_wr_pending && w_full);

   assign cpu_data  = r_cpu_data;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

`ifdef CPU_MEM_BRIDGE_FWD_EN
   logic [c_IW-1:0] w_rd_idx;
   logic [c_IW:0]   w_count;
   logic [AW-1:0]   w_ent_addr [WBUF_DEPTH];
   logic [DW-1:0]   w_ent_data [WBUF_DEPTH];
`endif

   wbuf_fifo #(
      .AW    (AW),
      .DW    (DW),
      .DEPTH (WBUF_DEPTH)
   ) u_wbuf (
      .clock     (clock),
      .reset     (reset),
      .push      (w_push),
      .push_addr (cpu_address),
      .push_data (cpu_datao),
      .pop       (w_pop),
      .full      (w_full),
      .empty     (w_empty),
      .head_addr (w_head_addr),
      .head_data (w_head_data)
`ifdef CPU_MEM_BRIDGE_FWD_EN
      ,
      .rd_idx    (w_rd_idx),
      .count     (w_count),
      .ent_addr  (w_ent_addr),
      .ent_data  (w_ent_data)
`endif
   );

`ifdef CPU_MEM_BRIDGE_FWD_EN
   // Walk oldest to youngest so the last match seen is the youngest write.
   always_comb begin
      w_fwd_hit  = 1'b0;
      w_fwd_data = '0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
         if (((c_IW+1)'(i) < w_count) &&
             (w_ent_addr[w_rd_idx + c_IW'(i)] == cpu_address)) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = w_ent_data[w_rd_idx + c_IW'(i)];
         end
      end
   end
`else
   assign w_fwd_hit  = 1'b0;
   assign w_fwd_data = '0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      w_issue_wr   = 1'b0;
      w_issue_rd   = 1'b0;
      w_cap_rd     = 1'b0;
      w_cap_fwd    = 1'b0;
      w_drop_req   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rd_pending && w_fwd_hit) begin
               w_cap_fwd    = 1'b1;
               w_state_next = RD_DONE;
            end else if (!w_empty) begin
               w_issue_wr   = 1'b1;
               w_state_next = WR_REQ;
            end else if (w_rd_pending) begin
               w_issue_rd   = 1'b1;
               w_state_next = RD_REQ;
            end
         end
         WR_REQ: begin
            if (w_ack) begin
               w_pop        = 1'b1;
               w_drop_req   = 1'b1;
               w_state_next = IDLE;
            end
         end
         RD_REQ: begin
            if (w_ack) begin
               w_cap_rd     = 1'b1;
               w_drop_req   = 1'b1;
               w_state_next = RD_DONE;
            end
         end
         RD_DONE: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_cpu_data  <= '0;
      end else begin
         if (w_issue_wr) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= w_head_addr;
            r_mem_wdata <= w_head_data;
         end else if (w_issue_rd) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= cpu_address;
         end else if (w_drop_req) begin
            r_mem_req   <= 1'b0;
         end
         if (w_cap_rd) begin
            r_cpu_data <= mem_rdata;
         end else if (w_cap_fwd) begin
            r_cpu_data <= w_fwd_data;
         end
      end
   end

endmodule

`default_nettype wire
